// File: rtl/rrp_pkg.sv
// Shared types and width helpers for the rRp adder scheduler.
package rrp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_e;

  function automatic int digit_width(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int opnd_width(input int radix, input int width);
    return digit_width(radix) * width;
  endfunction

  function automatic int sum_width(input int radix, input int width);
    return opnd_width(radix, width) + digit_width(radix);
  endfunction

endpackage

// File: rtl/rrp_res_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is taken only alongside a pop.
module rrp_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic                         valid,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((int'(count) < DEPTH) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Gate the head so an empty FIFO presents zeros, including straight out of reset.
  assign dout = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rrp_add_sched.sv
// Round-robin scheduler sharing one rRp online adder among NREQ requesters.
// Optional RRP_SCHED_STATS_EN adds per-requester saturating transfer counters on stat_issued.
module rrp_add_sched import rrp_pkg::*; #(
  parameter int RADIX      = 4,
  parameter int WIDTH      = 3,
  parameter int NREQ       = 3,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int D   = digit_width(RADIX),
  localparam int N   = opnd_width(RADIX, WIDTH),
  localparam int S   = sum_width(RADIX, WIDTH),
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_x,
  input  logic [NREQ*N-1:0]   req_y,
  input  logic                flush,
  output logic                flush_done,
  output logic [N-1:0]        add_x,
  output logic [N-1:0]        add_y,
  input  logic [S-1:0]        add_s,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [S-1:0]        res_s,
  output logic [IDW-1:0]      res_id
`ifdef RRP_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]  stat_issued
`endif
);

  sched_state_e state, state_nxt;

  logic [IDW-1:0]               ptr, gnt_id, idx;
  logic                         gnt_any, credit, xfer, any_valid, done_seen, res_pop;
  logic [N-1:0]                 gnt_x, gnt_y;
  logic [ADD_LAT:0]             vld_pipe;
  logic [ADD_LAT:0][IDW-1:0]    id_pipe;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic [S+IDW-1:0]             fifo_dout;
  int                           inflight;

  assign any_valid = |req_valid;
  assign res_pop   = res_valid && res_ready;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= ADD_LAT; i++) inflight += int'(vld_pipe[i]);
  end

  // Outstanding work (pipe + FIFO) less the entry leaving this cycle must leave a free slot.
  assign credit = (inflight + int'(fifo_count) - int'(res_pop)) < FIFO_DEPTH;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    gnt_x = '0;
    gnt_y = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_id == IDW'(r)) begin
        gnt_x = req_x[r*N +: N];
        gnt_y = req_y[r*N +: N];
      end
    end
  end

  always_comb begin
    xfer      = (state == RUN) && !flush && credit && gnt_any;
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = DRAIN;
               else if (any_valid) state_nxt = RUN;
      RUN:     if (flush) state_nxt = DRAIN;
               else if (!any_valid && inflight == 0) state_nxt = IDLE;
      DRAIN:   if (inflight == 0 && fifo_count == '0) state_nxt = DONE;
      DONE:    if (!flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign flush_done = (state == DONE) && !done_seen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      done_seen <= 1'b0;
      ptr       <= '0;
      add_x     <= '0;
      add_y     <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
    end else begin
      state     <= state_nxt;
      done_seen <= (state == DONE);
      if (xfer) ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
      add_x     <= xfer ? gnt_x : '0;
      add_y     <= xfer ? gnt_y : '0;
      vld_pipe  <= {vld_pipe[ADD_LAT-1:0], xfer};
      id_pipe   <= {id_pipe[ADD_LAT-1:0], gnt_id};
    end
  end

  // The last tag stage lines up with the adder's sum for that issue.
  rrp_res_fifo #(.W(S + IDW), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (vld_pipe[ADD_LAT]),
    .din     ({add_s, id_pipe[ADD_LAT]}),
    .pop     (res_ready),
    .valid   (res_valid),
    .dout    (fifo_dout),
    .count   (fifo_count)
  );

  assign {res_s, res_id} = fifo_dout;

`ifdef RRP_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] stat_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else if (xfer && stat_q[gnt_id] != 16'hFFFF) begin
      stat_q[gnt_id] <= stat_q[gnt_id] + 16'd1;
    end
  end

  assign stat_issued = stat_q;
`endif

endmodule

// File: tb/tb_rrp_add_sched.sv
// Randomized scoreboard bench for rrp_add_sched with a transaction-level reference model.
module tb_rrp_add_sched;

  localparam int NREQ = 3, FIFO_DEPTH = 4;
  localparam int D = 3, N = 9, S = 12, IDW = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic                clock = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*N-1:0]   req_x, req_y;
  logic                flush, flush_done;
  logic [N-1:0]        add_x, add_y;
  logic [S-1:0]        add_s;
  logic                res_valid, res_ready;
  logic [S-1:0]        res_s;
  logic [IDW-1:0]      res_id;
`ifdef RRP_SCHED_STATS_EN
  logic [NREQ*16-1:0]  stat_issued;
`endif

  always #5 clock = ~clock;

  rrp_add_sched #(.RADIX(4), .WIDTH(3), .NREQ(NREQ), .ADD_LAT(2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .flush      (flush),
    .flush_done (flush_done),
    .add_x      (add_x),
    .add_y      (add_y),
    .add_s      (add_s),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_id     (res_id)
`ifdef RRP_SCHED_STATS_EN
    ,
    .stat_issued(stat_issued)
`endif
  );

  function automatic logic [S-1:0] ref_sum(input logic [N-1:0] x, input logic [N-1:0] y);
    return {{D{x[N-1]}}, x} + {{D{y[N-1]}}, y};
  endfunction

  // Stand-in for the shared adder: operands registered, then sum registered.
  logic [N-1:0] ax_r, ay_r;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ax_r <= '0; ay_r <= '0; add_s <= '0;
    end else begin
      ax_r <= add_x; ay_r <= add_y; add_s <= ref_sum(ax_r, ay_r);
    end
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [S-1:0]   s;
  } exp_t;

  exp_t sbq[$];
  int   tq[$];
  int   m_state, m_ptr, m_xfers, m_pops, m_done_cyc, edge_n;
  int   m_stat[NREQ];
  logic [N-1:0] m_ax, m_ay;
  int   dut_xfers, done_pulses;
  int   n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete(); tq.delete();
    m_state = M_IDLE; m_ptr = 0; m_xfers = 0; m_pops = 0; m_done_cyc = 0;
    m_ax = '0; m_ay = '0;
    for (int r = 0; r < NREQ; r++) m_stat[r] = 0;
  endtask

  task automatic rand_ops();
    int t;
    for (int r = 0; r < NREQ; r++) begin
      t = $urandom; req_x[r*N +: N] = t[N-1:0];
      t = $urandom; req_y[r*N +: N] = t[N-1:0];
    end
  endtask

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic step();
    int outstanding, inflight, g, nxt;
    bit pop_now, any;
    logic [NREQ-1:0] eg;
    #1;
    while (tq.size() > 0 && tq[0] + 3 <= edge_n) void'(tq.pop_front());
    inflight    = tq.size();
    outstanding = m_xfers - m_pops;
    pop_now     = res_ready && (outstanding - inflight > 0);
    any         = |req_valid;
    g = -1; eg = '0;
    if (m_state == M_RUN && !flush && (outstanding - int'(pop_now)) < FIFO_DEPTH)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", req_ready, eg);
    check("flush_done", flush_done, (m_state == M_DONE && m_done_cyc == 0));
    check("add_x", add_x, m_ax);
    check("add_y", add_y, m_ay);
    if (flush_done) done_pulses++;
    if ((req_ready & req_valid) != '0) dut_xfers++;
    m_ax = '0; m_ay = '0;
    if (g >= 0) begin
      m_ax = req_x[g*N +: N];
      m_ay = req_y[g*N +: N];
      sbq.push_back('{id: IDW'(g), s: ref_sum(m_ax, m_ay)});
      tq.push_back(edge_n + 1);
      m_xfers++;
      m_stat[g]++;
      m_ptr = (g + 1) % NREQ;
    end
    nxt = m_state;
    case (m_state)
      M_IDLE:  if (flush) nxt = M_DRAIN; else if (any) nxt = M_RUN;
      M_RUN:   if (flush) nxt = M_DRAIN; else if (!any && inflight == 0) nxt = M_IDLE;
      M_DRAIN: if (outstanding == 0 && inflight == 0) nxt = M_DONE;
      default: if (!flush) nxt = M_IDLE;
    endcase
    m_done_cyc = (m_state == M_DONE) ? m_done_cyc + 1 : 0;
    @(posedge clock);
    edge_n++;
    m_state = nxt;
    @(negedge clock);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands a result over.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock); #2;
      if (reset_n && res_valid) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL res_unexpected: res_valid=1 id=%0d s=%0h with nothing outstanding", res_id, res_s);
        end else if (res_ready) begin
          e = sbq.pop_front();
          check("res_id", res_id, e.id);
          check("res_s", res_s, e.s);
          m_pops++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : drive
    int base, base_p, guard, flush_left;
    reset_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; flush = 1'b0; res_ready = 1'b1;
    edge_n = 0; dut_xfers = 0; done_pulses = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_s", res_s, 0);
    check("rst_res_id", res_id, 0);
    check("rst_flush_done", flush_done, 0);
    reset_n = 1'b1;

    // Single request from r1, x digits {1,2,-1}, y digits {1,1,1}.
    req_x[1*N +: N] = 9'b001_010_111;
    req_y[1*N +: N] = 9'b001_001_001;
    req_valid = 3'b010;
    step(); step();
    req_valid = '0;
    check("single_xfer", dut_xfers, 1);
    for (int k = 0; k < 4; k++) begin
      check("single_latency", res_valid, (k == 3));
      if (k < 3) step();
    end
    repeat (4) step();

    // All requesters streaming, results consumed every cycle.
    req_valid = '1; rand_ops(); step();
    base = dut_xfers;
    repeat (12) begin rand_ops(); step(); end
    check("stream_rate", dut_xfers - base, 12);
    req_valid = '0; repeat (8) step();

    // Consumer stalled: credit stops issue at FIFO_DEPTH.
    req_valid = '1; res_ready = 1'b0; base = dut_xfers;
    repeat (10) begin rand_ops(); step(); end
    check("stall_xfers", dut_xfers - base, FIFO_DEPTH);
    check("stall_res_valid", res_valid, 1);
    res_ready = 1'b1;
    repeat (10) begin rand_ops(); step(); end
    req_valid = '0; repeat (8) step();
    check("stall_drained", sbq.size(), 0);

    // Flush with two sums in flight.
    req_valid = '1; rand_ops(); step(); step(); step();
    flush = 1'b1; base = dut_xfers; base_p = done_pulses; guard = 0;
    while (done_pulses == base_p && guard < 30) begin step(); guard++; end
    check("flush_done_seen", done_pulses - base_p, 1);
    repeat (3) step();
    check("flush_no_grant", dut_xfers - base, 0);
    check("flush_single_pulse", done_pulses - base_p, 1);
    check("flush_drained", sbq.size(), 0);
    flush = 1'b0; req_valid = '0; repeat (3) step();

    // Randomized traffic with occasional flushes and consumer back-pressure.
    flush_left = 0;
    repeat (300) begin
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      if (flush_left > 0) begin
        flush = 1'b1; flush_left--;
      end else begin
        flush = 1'b0;
        if ($urandom_range(0, 39) == 0) flush_left = $urandom_range(1, 8);
      end
      step();
    end
    flush = 1'b0; req_valid = '0; res_ready = 1'b1;
    repeat (10) step();
    check("random_drained", sbq.size(), 0);

    // Reset while busy: everything in flight is discarded.
    req_valid = '1; res_ready = 1'b0;
    repeat (5) begin rand_ops(); step(); end
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_add_x", add_x, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_s", res_s, 0);
    check("mid_rst_res_id", res_id, 0);
    model_reset();
    repeat (2) @(negedge clock);
    req_valid = '0; res_ready = 1'b1; reset_n = 1'b1;
    repeat (8) step();
    check("post_rst_res_valid", res_valid, 0);

    // Five transfers from r2 only.
    req_valid = 3'b100; guard = 0;
    while (m_stat[2] < 5 && guard < 40) begin rand_ops(); step(); guard++; end
    req_valid = '0;
    repeat (8) step();
    check("r2_results_drained", sbq.size(), 0);
`ifdef RRP_SCHED_STATS_EN
    for (int r = 0; r < NREQ; r++)
      check($sformatf("stat_issued_%0d", r), stat_issued[r*16 +: 16], m_stat[r]);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
